ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  EX->MEM pipeline register directly downstream of the EX-stage ALU. Captures ALU results
//  (alu_result, alu_result_high, alu_zero) plus destination/memory/HI-LO side-band for one
//  instruction. Uses a valid/ready handshake with a 2-entry skid buffer, so MEM back-pressure
//  never creates a combinational ready path back into EX. Pipeline flush discards all held state.
// PARAMETERS
//  DATA_W   32  datapath width (alu_result, alu_result_high, store data, pc)
//  REG_AW   5   register-file address width
//  MEMOP_W  4   memory-op encoding width (encodings in cpu_defs_pkg)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  resetn         in   1        asynchronous, active-low reset
//  flush          in   1        discard in-flight + buffered entries (exception/branch squash)
//  ex_valid       in   1        EX presents an instruction this cycle
//  ex_ready       out  1        register can accept; registered output, no combinational input path
//  ex_pc          in   DATA_W   instruction PC
//  ex_alu_result  in   DATA_W   ALU low result / effective address
//  ex_alu_high    in   DATA_W   ALU high result (mul/div HI)
//  ex_alu_zero    in   1        ALU compare flag
//  ex_wdata       in   DATA_W   store data (rt value)
//  ex_rd          in   REG_AW   destination register; 0 = no write
//  ex_reg_we      in   1        register write enable
//  ex_hilo_we     in   1        write HI<=alu_high, LO<=alu_result
//  ex_memop       in   MEMOP_W  memory operation; MEMOP_NONE = no access
//  mem_valid      out  1        output slot holds a valid instruction
//  mem_ready      in   1        MEM consumes output slot this cycle
//  mem_pc, mem_alu_result, mem_alu_high, mem_alu_zero, mem_wdata, mem_rd, mem_reg_we,
//  mem_hilo_we, mem_memop   out  same widths as ex_*   registered payload
// BEHAVIOUR
//  - Reset (async assert, sync release): mem_valid=0, ex_ready=1, all payload outputs 0, skid empty.
//  - Transfer in  = ex_valid & ex_ready; transfer out = mem_valid & mem_ready.
//  - Latency: one cycle EX->MEM when unstalled; full throughput (1 instr/cycle) when mem_ready=1.
//  - ex_ready = ~skid_valid (registered). Input accepted while output slot is full and not
//    draining goes to the skid entry; next cycle ex_ready=0.
//  - State (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) is unreachable.
//    EMPTY: in -> ONE.  ONE: in&out -> ONE (new payload); in&~out -> FULL; out&~in -> EMPTY.
//    FULL: out -> ONE (skid moves to main, ex_ready=1 next cycle); ~out -> hold.
//  - Ordering strictly FIFO; skid entry always drains before any newer input.
//  - flush=1: next cycle EMPTY, ex_ready=1, mem_valid=0; flush beats simultaneous in/out
//    (same-cycle input dropped, same-cycle output still counted as consumed by MEM).
//  - Invalid slot forces mem_reg_we, mem_hilo_we to 0 and mem_memop to MEMOP_NONE; other
//    payload holds its last value.
//  - Payload held stable while mem_valid & ~mem_ready (no change without a transfer).
//  - ex_rd==0 with ex_reg_we=1: mem_reg_we forced 0.
//  - No arithmetic: widths pass through unchanged; no sign/zero extension.
// STRUCTURE
//  - cpu_defs_pkg: DATA_W/REG_AW/MEMOP_W constants, MEMOP_* encodings (NONE, LB, LBU, LH, LHU,
//    LW, SB, SH, SW), ex_mem_payload struct/concatenation layout shared with MEM stage.
//  - One sub-module ex_mem_slot: a single payload register with load enable and valid bit,
//    instantiated twice (main, skid); control FSM lives in the top.
// TESTING
//  1 reset mid-stream: resetn=0 while FULL -> same cycle mem_valid=0, ex_ready=1, payload 0.
//  2 streaming: 4 back-to-back ADDU results 0x1,0x2,0x3,0x4 with mem_ready=1 -> appear on
//    mem_alu_result on consecutive cycles, 1-cycle latency, ex_ready stays 1.
//  3 back-pressure: mem_ready=0 for 3 cycles while EX sends A=0x10, B=0x20 -> A held, B in
//    skid, ex_ready=0; mem_ready=1 -> A then B, ex_ready=1 one cycle after A leaves.
//  4 flush while FULL with ex_valid=1 (C=0x30) -> next cycle mem_valid=0, C never appears.
//  5 side-band: ex_hilo_we=1, high=0xDEADBEEF, result=0x12345678 -> same cycle on mem_*; rd=0
//    with reg_we=1 -> mem_reg_we=0; bubble -> mem_memop=MEMOP_NONE.
//  6 random valid/ready (10k cycles) vs. scoreboard FIFO: no loss, no duplicate, order kept.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, memory-op encodings
// and the EX->MEM payload layout used by both EX and MEM stages.
package cpu_defs_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int MEMOP_W = 4;

    typedef enum logic [MEMOP_W-1:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LBU  = 4'd2,
        MEMOP_LH   = 4'd3,
        MEMOP_LHU  = 4'd4,
        MEMOP_LW   = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  alu_high;
        logic               alu_zero;
        logic [DATA_W-1:0]  wdata;
        logic [REG_AW-1:0]  rd;
        logic               reg_we;
        logic               hilo_we;
        logic [MEMOP_W-1:0] memop;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register plus valid bit; load wins over clear.
// Used for both the main output slot and the skid entry.
module ex_mem_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer so that
// ex_ready is purely registered (no combinational path from mem_ready).
module ex_mem_pipe_reg
    import cpu_defs_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [DATA_W-1:0]  ex_pc,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic [DATA_W-1:0]  ex_alu_high,
    input  logic               ex_alu_zero,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic               ex_reg_we,
    input  logic               ex_hilo_we,
    input  logic [MEMOP_W-1:0] ex_memop,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [DATA_W-1:0]  mem_pc,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [DATA_W-1:0]  mem_alu_high,
    output logic               mem_alu_zero,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               mem_reg_we,
    output logic               mem_hilo_we,
    output logic [MEMOP_W-1:0] mem_memop
);

    ex_mem_payload_t in_p;
    ex_mem_payload_t main_p;

    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] main_d;

    logic main_v;
    logic skid_v;
    logic in_xfer;
    logic out_xfer;
    logic main_load;
    logic main_clr;
    logic skid_load;
    logic skid_clr;

    // r0 is hardwired; drop the write here so MEM/WB never see it
    always_comb begin
        in_p.pc         = ex_pc;
        in_p.alu_result = ex_alu_result;
        in_p.alu_high   = ex_alu_high;
        in_p.alu_zero   = ex_alu_zero;
        in_p.wdata      = ex_wdata;
        in_p.rd         = ex_rd;
        in_p.reg_we     = ex_reg_we & (ex_rd != '0);
        in_p.hilo_we    = ex_hilo_we;
        in_p.memop      = ex_memop;
    end

    assign ex_ready = ~skid_v;
    assign in_xfer  = ex_valid & ex_ready;
    assign out_xfer = main_v & mem_ready;

    // FULL drains skid into main; otherwise new input goes to main
    // whenever main is free or leaving, else parks in skid.
    assign main_load = ~flush & (skid_v ? out_xfer
                                        : in_xfer & (out_xfer | ~main_v));
    assign main_d    = skid_v ? skid_q : PAYLOAD_W'(in_p);
    assign main_clr  = flush | out_xfer;

    assign skid_load = ~flush & ~skid_v & in_xfer & main_v & ~out_xfer;
    assign skid_clr  = flush | out_xfer;

    ex_mem_slot #(.W(PAYLOAD_W)) u_main (
        .clk    (clk),
        .resetn (resetn),
        .load   (main_load),
        .clear  (main_clr),
        .d      (main_d),
        .valid  (main_v),
        .q      (main_q)
    );

    ex_mem_slot #(.W(PAYLOAD_W)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .load   (skid_load),
        .clear  (skid_clr),
        .d      (PAYLOAD_W'(in_p)),
        .valid  (skid_v),
        .q      (skid_q)
    );

    assign main_p = ex_mem_payload_t'(main_q);

    assign mem_valid      = main_v;
    assign mem_pc         = main_p.pc;
    assign mem_alu_result = main_p.alu_result;
    assign mem_alu_high   = main_p.alu_high;
    assign mem_alu_zero   = main_p.alu_zero;
    assign mem_wdata      = main_p.wdata;
    assign mem_rd         = main_p.rd;
    assign mem_reg_we     = main_v & main_p.reg_we;
    assign mem_hilo_we    = main_v & main_p.hilo_we;
    assign mem_memop      = main_v ? main_p.memop : MEMOP_NONE;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed scenarios followed
// by random valid/ready/flush traffic against a 2-deep FIFO model.
module tb_ex_mem_pipe_reg;
    import cpu_defs_pkg::*;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               flush = 1'b0;
    logic               ex_valid = 1'b0;
    logic               ex_ready;
    logic [DATA_W-1:0]  ex_pc = '0;
    logic [DATA_W-1:0]  ex_alu_result = '0;
    logic [DATA_W-1:0]  ex_alu_high = '0;
    logic               ex_alu_zero = 1'b0;
    logic [DATA_W-1:0]  ex_wdata = '0;
    logic [REG_AW-1:0]  ex_rd = '0;
    logic               ex_reg_we = 1'b0;
    logic               ex_hilo_we = 1'b0;
    logic [MEMOP_W-1:0] ex_memop = '0;
    logic               mem_valid;
    logic               mem_ready = 1'b0;
    logic [DATA_W-1:0]  mem_pc;
    logic [DATA_W-1:0]  mem_alu_result;
    logic [DATA_W-1:0]  mem_alu_high;
    logic               mem_alu_zero;
    logic [DATA_W-1:0]  mem_wdata;
    logic [REG_AW-1:0]  mem_rd;
    logic               mem_reg_we;
    logic               mem_hilo_we;
    logic [MEMOP_W-1:0] mem_memop;

    ex_mem_pipe_reg dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_alu_result  (ex_alu_result),
        .ex_alu_high    (ex_alu_high),
        .ex_alu_zero    (ex_alu_zero),
        .ex_wdata       (ex_wdata),
        .ex_rd          (ex_rd),
        .ex_reg_we      (ex_reg_we),
        .ex_hilo_we     (ex_hilo_we),
        .ex_memop       (ex_memop),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_pc         (mem_pc),
        .mem_alu_result (mem_alu_result),
        .mem_alu_high   (mem_alu_high),
        .mem_alu_zero   (mem_alu_zero),
        .mem_wdata      (mem_wdata),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_hilo_we    (mem_hilo_we),
        .mem_memop      (mem_memop)
    );

    always #5 clk = ~clk;

    ex_mem_payload_t sb[$];
    ex_mem_payload_t e;
    int checks = 0;
    int failures = 0;
    logic side = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the register is a FIFO of depth 2; the queue holds exactly
    // what the DUT holds at each falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            chk("mem_valid", 64'(mem_valid), 64'(sb.size() > 0));
            chk("ex_ready", 64'(ex_ready), 64'(sb.size() < 2));
            if (mem_valid && sb.size() > 0) begin
                e = sb[0];
                chk("pc", 64'(mem_pc), 64'(e.pc));
                chk("alu_result", 64'(mem_alu_result), 64'(e.alu_result));
                chk("alu_high", 64'(mem_alu_high), 64'(e.alu_high));
                chk("alu_zero", 64'(mem_alu_zero), 64'(e.alu_zero));
                chk("wdata", 64'(mem_wdata), 64'(e.wdata));
                chk("rd", 64'(mem_rd), 64'(e.rd));
                chk("reg_we", 64'(mem_reg_we), 64'(e.reg_we));
                chk("hilo_we", 64'(mem_hilo_we), 64'(e.hilo_we));
                chk("memop", 64'(mem_memop), 64'(e.memop));
                if (mem_ready) void'(sb.pop_front());
            end else if (!mem_valid) begin
                chk("bubble_reg_we", 64'(mem_reg_we), 64'd0);
                chk("bubble_hilo_we", 64'(mem_hilo_we), 64'd0);
                chk("bubble_memop", 64'(mem_memop), 64'(MEMOP_NONE));
            end
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] res,
                       input logic mr, input logic fl);
        logic acc;
        ex_mem_payload_t x;
        @(posedge clk);
        #1;
        ex_valid      = v;
        mem_ready     = mr;
        flush         = fl;
        ex_alu_result = res;
        ex_pc         = $urandom;
        ex_alu_high   = $urandom;
        ex_alu_zero   = 1'($urandom);
        ex_wdata      = $urandom;
        ex_rd         = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
        ex_reg_we     = 1'($urandom);
        ex_hilo_we    = 1'($urandom);
        ex_memop      = MEMOP_W'($urandom_range(0, 8));
        if (side) begin
            ex_alu_high = 32'hDEADBEEF;
            ex_hilo_we  = 1'b1;
            ex_rd       = '0;
            ex_reg_we   = 1'b1;
        end
        acc = v & ex_ready & ~fl;
        x.pc         = ex_pc;
        x.alu_result = ex_alu_result;
        x.alu_high   = ex_alu_high;
        x.alu_zero   = ex_alu_zero;
        x.wdata      = ex_wdata;
        x.rd         = ex_rd;
        x.reg_we     = ex_reg_we && ex_rd != 0;
        x.hilo_we    = ex_hilo_we;
        x.memop      = ex_memop;
        @(negedge clk);
        #1;
        if (fl) sb.delete();
        if (acc) sb.push_back(x);
    endtask

    initial begin
        #2;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_result", 64'(mem_alu_result), 64'd0);
        chk("rst_memop", 64'(mem_memop), 64'(MEMOP_NONE));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h30, 1'b0, 1'b1);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h30, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        side = 1'b1;
        cyc(1'b1, 32'h12345678, 1'b1, 1'b0);
        side = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("side_high", 64'(mem_alu_high), 64'hDEADBEEF);
        chk("side_result", 64'(mem_alu_result), 64'h12345678);
        chk("side_hilo_we", 64'(mem_hilo_we), 64'd1);
        chk("side_rd0_reg_we", 64'(mem_reg_we), 64'd0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("side_bubble_memop", 64'(mem_memop), 64'(MEMOP_NONE));

        cyc(1'b1, 32'h50, 1'b0, 1'b0);
        cyc(1'b1, 32'h60, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
        chk("midrst_ex_ready", 64'(ex_ready), 64'd1);
        chk("midrst_result", 64'(mem_alu_result), 64'd0);
        chk("midrst_pc", 64'(mem_pc), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(0, 3) != 0), $urandom,
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 63) == 0));
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
